alu_flag_wb: RTL and testbench

ALU_FLAG_WB -- requirements
Module: alu_flag_wb

---
 rtl/alu_wb_pkg.sv | 32 +++
 rtl/alu_flag_wb_if.sv | 32 +++
 rtl/alu_cc_eval.sv | 27 ++
 rtl/alu_flag_wb.sv | 103 ++++++++++
 tb/tb_alu_flag_wb.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU flag / writeback block: flag layout,
// update-enable positions, FSM encoding and condition codes.
package alu_wb_pkg;

    // Bit positions of the flags inside the 8-bit F register.
    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    // fupd bits line up with the upper F nibble, i.e. F[FLAG_x] <-> fupd[FLAG_x-FLAG_C].
    localparam int FUPD_Z = 3;
    localparam int FUPD_N = 2;
    localparam int FUPD_H = 1;
    localparam int FUPD_C = 0;

    // High-byte pass of a pair operation never touches Z.
    localparam logic [3:0] PAIR_FUPD_MASK = 4'b0111;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_LO_DONE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CC_NZ = 2'b00,
        CC_Z  = 2'b01,
        CC_NC = 2'b10,
        CC_C  = 2'b11
    } cc_t;

endpackage

// File: rtl/alu_flag_wb_if.sv
// ALU-side bundle into the flag/writeback block; master is the ALU/sequencer,
// slave is alu_flag_wb.
interface alu_flag_wb_if;
    logic        res_valid;
    logic [7:0]  Res;
    logic        co;
    logic        ho;
    logic        sub;
    logic [3:0]  fupd;
    logic        pair_start;
    logic        f_load;
    logic [7:0]  din;
    logic [1:0]  cc;

    logic [7:0]  F;
    logic [15:0] wb_data;
    logic        wb_valid;
    logic        wb_wide;
    logic        cin_to_alu;
    logic        busy;
    logic        cc_true;

    modport master (
        output res_valid, Res, co, ho, sub, fupd, pair_start, f_load, din, cc,
        input  F, wb_data, wb_valid, wb_wide, cin_to_alu, busy, cc_true
    );

    modport slave (
        input  res_valid, Res, co, ho, sub, fupd, pair_start, f_load, din, cc,
        output F, wb_data, wb_valid, wb_wide, cin_to_alu, busy, cc_true
    );
endinterface

// File: rtl/alu_cc_eval.sv
// Branch condition evaluation on the flag nibble {Z,N,H,C}.
module alu_cc_eval
    import alu_wb_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [1:0] cc,
    output logic       cc_true
);

    logic flag_z;
    logic flag_c;

    assign flag_z = flags[FLAG_Z - FLAG_C];
    assign flag_c = flags[FLAG_C - FLAG_C];

    always_comb begin
        cc_true = 1'b0;
        case (cc_t'(cc))
            CC_NZ:   cc_true = ~flag_z;
            CC_Z:    cc_true = flag_z;
            CC_NC:   cc_true = ~flag_c;
            CC_C:    cc_true = flag_c;
            default: cc_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_wb.sv
// Flag register and result writeback for an 8-bit ALU, including two-pass
// 16-bit pair operations with carry handoff between the byte passes.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no pair in flight; byte results write back directly
// ST_LO_DONE | low byte of a pair captured, waiting for the high-byte pass
module alu_flag_wb
    import alu_wb_pkg::*;
(
    input  logic          CLK,
    input  logic          nRESET,
    alu_flag_wb_if.slave  bus
);

    state_t      state;
    logic [3:0]  flags_q;
    logic [3:0]  flags_nxt;
    logic [3:0]  upd_mask;
    logic [3:0]  alu_flags;
    logic [7:0]  lo_byte;
    logic [15:0] wb_data_q;
    logic        wb_valid_q;
    logic        wb_wide_q;
    logic        cin_q;
    logic        busy_q;
    logic        res_zero;

    assign res_zero  = (bus.Res == 8'h00);
    assign alu_flags = {res_zero, bus.sub, bus.ho, bus.co};

    always_comb begin
        upd_mask = 4'b0000;
        if (bus.res_valid) begin
            case (state)
                ST_IDLE:    upd_mask = bus.pair_start ? 4'b0000 : bus.fupd;
                ST_LO_DONE: upd_mask = bus.fupd & PAIR_FUPD_MASK;
                default:    upd_mask = 4'b0000;
            endcase
        end
    end

    // POP AF overrides whatever the ALU wants to write this cycle.
    assign flags_nxt = bus.f_load ? bus.din[FLAG_Z:FLAG_C]
                                  : (flags_q & ~upd_mask) | (alu_flags & upd_mask);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= ST_IDLE;
            flags_q    <= 4'b0000;
            lo_byte    <= 8'h00;
            wb_data_q  <= 16'h0000;
            wb_valid_q <= 1'b0;
            wb_wide_q  <= 1'b0;
            cin_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            flags_q    <= flags_nxt;
            wb_valid_q <= 1'b0;
            wb_wide_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.res_valid) begin
                        if (bus.pair_start) begin
                            lo_byte <= bus.Res;
                            cin_q   <= bus.co;
                            busy_q  <= 1'b1;
                            state   <= ST_LO_DONE;
                        end else begin
                            wb_data_q  <= {8'h00, bus.Res};
                            wb_valid_q <= 1'b1;
                        end
                    end
                end
                ST_LO_DONE: begin
                    if (bus.res_valid) begin
                        wb_data_q  <= {bus.Res, lo_byte};
                        wb_valid_q <= 1'b1;
                        wb_wide_q  <= 1'b1;
                        cin_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.F          = {flags_q, 4'b0000};
    assign bus.wb_data    = wb_data_q;
    assign bus.wb_valid   = wb_valid_q;
    assign bus.wb_wide    = wb_wide_q;
    assign bus.cin_to_alu = cin_q;
    assign bus.busy       = busy_q;

    alu_cc_eval u_cc_eval (
        .flags   (flags_q),
        .cc      (bus.cc),
        .cc_true (bus.cc_true)
    );

endmodule

// File: tb/tb_alu_flag_wb.sv
// Self-checking bench for alu_flag_wb: directed vector table, hand-written
// reset/condition sequences, and random ALU traffic against a reference model.
module tb_alu_flag_wb;

    logic clk;
    logic nreset;
    int   n_total;
    int   n_bad;

    alu_flag_wb_if bus ();

    alu_flag_wb u_dut (
        .CLK    (clk),
        .nRESET (nreset),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        ps;
        logic [7:0]  res;
        logic        co;
        logic        ho;
        logic        sub;
        logic [3:0]  fupd;
        logic        fl;
        logic [7:0]  din;
        logic [7:0]  e_f;
        logic        e_v;
        logic        e_w;
        logic [15:0] e_d;
        logic        e_busy;
        logic        e_cin;
    } vec_t;

    vec_t vecs [12];

    // reference model state: flags as {Z,N,H,C}, plus pair bookkeeping
    logic [3:0]  m_flags;
    logic        m_busy;
    logic [7:0]  m_lo;
    logic        m_cin;
    logic        m_valid;
    logic        m_wide;
    logic [15:0] m_data;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic ps, input logic [7:0] res, input logic co,
                         input logic ho, input logic sub, input logic [3:0] fupd,
                         input logic fl, input logic [7:0] din);
        bus.res_valid  = rv;
        bus.pair_start = ps;
        bus.Res        = res;
        bus.co         = co;
        bus.ho         = ho;
        bus.sub        = sub;
        bus.fupd       = fupd;
        bus.f_load     = fl;
        bus.din        = din;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    function automatic logic cc_expect(input logic [7:0] f, input logic [1:0] cc);
        logic z;
        logic c;
        z = f[7];
        c = f[4];
        case (cc)
            2'd0:    return !z;
            2'd1:    return z;
            2'd2:    return !c;
            default: return c;
        endcase
    endfunction

    // One clock of the model: what the block must show after this edge.
    task automatic model_step(input logic rv, input logic ps, input logic [7:0] res, input logic co,
                              input logic ho, input logic sub, input logic [3:0] fupd,
                              input logic fl, input logic [7:0] din);
        logic [3:0] cand;
        logic [3:0] nf;
        cand    = {res == 8'h00, sub, ho, co};
        nf      = m_flags;
        m_valid = 1'b0;
        m_wide  = 1'b0;
        if (rv) begin
            if (m_busy) begin
                m_data  = {res, m_lo};
                m_valid = 1'b1;
                m_wide  = 1'b1;
                for (int i = 0; i < 3; i++) if (fupd[i]) nf[i] = cand[i];
                m_busy  = 1'b0;
                m_cin   = 1'b0;
            end else if (ps) begin
                m_lo   = res;
                m_cin  = co;
                m_busy = 1'b1;
            end else begin
                m_data  = {8'h00, res};
                m_valid = 1'b1;
                for (int i = 0; i < 4; i++) if (fupd[i]) nf[i] = cand[i];
            end
        end
        if (fl) nf = din[7:4];
        m_flags = nf;
    endtask

    task automatic do_reset();
        drive_idle();
        bus.cc = 2'b00;
        nreset = 1'b0;
        repeat (2) tick();
        nreset = 1'b1;
        m_flags = 4'h0;
        m_busy  = 1'b0;
        m_lo    = 8'h00;
        m_cin   = 1'b0;
        m_valid = 1'b0;
        m_wide  = 1'b0;
        m_data  = 16'h0000;
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] wide_sum;
        logic       rv;
        logic       ps;
        logic       sub;
        logic       co;
        logic       ho;
        logic [7:0] res;
        logic [3:0] fupd;
        logic       fl;
        logic [7:0] din;
        logic [7:0] f_now;
        logic [1:0] ccv;

        n_total = 0;
        n_bad   = 0;
        nreset  = 1'b0;

        //          rv    ps    res    co    ho    sub   fupd  fl    din      e_f    e_v   e_w   e_d       busy  cin
        vecs[0]  = '{1'b1, 1'b0, 8'h70, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 8'h00,  8'h20, 1'b1, 1'b0, 16'h0070, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00,  8'hF0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00,  8'hE0, 1'b1, 1'b0, 16'h0055, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00,  8'hE0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00,  8'hE0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00,  8'hE0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00,  8'h80, 1'b1, 1'b1, 16'h12FF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 8'hFF,  8'hF0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 8'h3C,  8'h30, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 8'hA5,  8'hA0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'h00,  8'hF0, 1'b1, 1'b1, 16'hCDAB, 1'b0, 1'b0};

        do_reset();
        check("rst_F",        16'(bus.F), 16'h0000);
        check("rst_wb_valid", 16'(bus.wb_valid), 16'h0000);
        check("rst_wb_data",  bus.wb_data, 16'h0000);
        check("rst_busy",     16'(bus.busy), 16'h0000);
        check("rst_cin",      16'(bus.cin_to_alu), 16'h0000);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rv, vecs[i].ps, vecs[i].res, vecs[i].co, vecs[i].ho, vecs[i].sub,
                  vecs[i].fupd, vecs[i].fl, vecs[i].din);
            tick();
            check($sformatf("vec%0d_F", i),     16'(bus.F), 16'(vecs[i].e_f));
            check($sformatf("vec%0d_valid", i), 16'(bus.wb_valid), 16'(vecs[i].e_v));
            check($sformatf("vec%0d_wide", i),  16'(bus.wb_wide), 16'(vecs[i].e_w));
            check($sformatf("vec%0d_busy", i),  16'(bus.busy), 16'(vecs[i].e_busy));
            check($sformatf("vec%0d_cin", i),   16'(bus.cin_to_alu), 16'(vecs[i].e_cin));
            if (vecs[i].e_v) check($sformatf("vec%0d_data", i), bus.wb_data, vecs[i].e_d);
        end
        drive_idle();
        tick();
        check("pulse_one_cycle", 16'(bus.wb_valid), 16'h0000);

        // reset while a pair is half done
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00);
        tick();
        check("midpair_busy", 16'(bus.busy), 16'h0001);
        drive_idle();
        nreset = 1'b0;
        #1;
        check("async_rst_busy", 16'(bus.busy), 16'h0000);
        check("async_rst_cin",  16'(bus.cin_to_alu), 16'h0000);
        check("async_rst_F",    16'(bus.F), 16'h0000);
        #2;
        nreset = 1'b1;
        tick();
        drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00);
        tick();
        check("post_rst_byte_wide", 16'(bus.wb_wide), 16'h0000);
        check("post_rst_byte_data", bus.wb_data, 16'h0022);
        drive(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 8'h00);
        tick();
        check("post_rst_pair_cin", 16'(bus.cin_to_alu), 16'h0001);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 8'h00);
        tick();
        check("post_rst_pair_data", bus.wb_data, 16'h0011);
        check("post_rst_pair_wide", 16'(bus.wb_wide), 16'h0001);
        check("post_rst_pair_F",    16'(bus.F), 16'h0020);

        // condition sweep on two fixed flag values
        for (int k = 0; k < 2; k++) begin
            f_now = (k == 0) ? 8'h80 : 8'h10;
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, f_now);
            tick();
            drive_idle();
            for (int c = 0; c < 4; c++) begin
                bus.cc = 2'(c);
                #1;
                check($sformatf("cc_F%h_cc%0d", f_now, c), 16'(bus.cc_true), 16'(cc_expect(f_now, 2'(c))));
            end
        end

        // random ALU traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            sub = 1'($urandom);
            if (sub) begin
                res = a - b;
                co  = (a < b);
                ho  = (a[3:0] < b[3:0]);
            end else begin
                wide_sum = {1'b0, a} + {1'b0, b};
                res = wide_sum[7:0];
                co  = wide_sum[8];
                ho  = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'h0F;
            end
            if ($urandom_range(0, 7) == 0) res = 8'h00;
            rv   = ($urandom_range(0, 3) != 0);
            ps   = ($urandom_range(0, 2) == 0);
            fupd = 4'($urandom);
            fl   = ($urandom_range(0, 9) == 0);
            din  = 8'($urandom);
            drive(rv, ps, res, co, ho, sub, fupd, fl, din);
            model_step(rv, ps, res, co, ho, sub, fupd, fl, din);
            tick();
            check("rnd_F",     16'(bus.F), 16'({m_flags, 4'b0000}));
            check("rnd_valid", 16'(bus.wb_valid), 16'(m_valid));
            check("rnd_wide",  16'(bus.wb_wide), 16'(m_wide));
            check("rnd_busy",  16'(bus.busy), 16'(m_busy));
            check("rnd_cin",   16'(bus.cin_to_alu), 16'(m_cin));
            if (m_valid) check("rnd_data", bus.wb_data, m_data);
            ccv    = 2'($urandom);
            bus.cc = ccv;
            #1;
            check("rnd_cc", 16'(bus.cc_true), 16'(cc_expect({m_flags, 4'b0000}, ccv)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
